// File: rtl/shift_arb_if.sv
// Request/response bundle for shift_arb: two requesters sharing one shifter,
// plus the pipeline flush. The master side is the requester/consumer.
interface shift_arb_if;
  logic        flush;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [1:0]  req0_op;
  logic [1:0]  req1_op;
  logic [31:0] req0_a;
  logic [31:0] req1_a;
  logic [4:0]  req0_sa;
  logic [4:0]  req1_sa;
  logic        resp0_valid;
  logic        resp1_valid;
  logic [31:0] resp0_data;
  logic [31:0] resp1_data;
  logic        resp0_ready;
  logic        resp1_ready;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a valid request holds its payload until ready, a held response is stable until taken.
  modport master (
    output flush, req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a,
           req0_sa, req1_sa, resp0_ready, resp1_ready,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data
  );

  modport slave (
    input  flush, req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a,
           req0_sa, req1_sa, resp0_ready, resp1_ready,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data
  );
endinterface

// File: rtl/shift_arb.sv
// Two-port round-robin arbiter in front of one 32-bit barrel shifter with a
// one-entry result register per port. SHIFT_ARB_ROTATE_EN enables op 11 as rotate-right.
module shift_arb (
  input  logic        clk,
  input  logic        rst,
  shift_arb_if.slave  bus
);

  logic        last_q, last_d;
  logic [1:0]  vld_q, vld_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;

  logic        elig0, elig1;
  logic        grant0, grant1;
  logic [1:0]  sel_op;
  logic [31:0] sel_a;
  logic [4:0]  sel_sa;
  logic [31:0] shift_res;

  // A port may load when its slot is empty or is being drained this same cycle.
  assign elig0 = bus.req0_valid && !bus.flush && !rst && (!vld_q[0] || bus.resp0_ready);
  assign elig1 = bus.req1_valid && !bus.flush && !rst && (!vld_q[1] || bus.resp1_ready);

  assign grant0 = elig0 && (!elig1 || last_q);
  assign grant1 = elig1 && (!elig0 || !last_q);

  assign sel_op = grant1 ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
  assign sel_sa = grant1 ? bus.req1_sa : bus.req0_sa;

`ifdef SHIFT_ARB_ROTATE_EN
  logic [4:0] neg_sa;
  // For sa=0 the left term is also a<<0, so the OR still returns a unchanged.
  assign neg_sa = 5'd0 - sel_sa;
`endif

  always_comb begin
    shift_res = '0;
    case (sel_op)
      2'b00:   shift_res = sel_a << sel_sa;
      2'b01:   shift_res = sel_a >> sel_sa;
      2'b10:   shift_res = $signed(sel_a) >>> sel_sa;
`ifdef SHIFT_ARB_ROTATE_EN
      default: shift_res = (sel_a >> sel_sa) | (sel_a << neg_sa);
`else
      default: shift_res = 32'h0000_0000;
`endif
    endcase
  end

  always_comb begin
    vld_d   = vld_q;
    data0_d = data0_q;
    data1_d = data1_q;
    last_d  = last_q;
    if (bus.flush) begin
      vld_d = 2'b00;
    end else begin
      if (grant0) begin
        vld_d[0] = 1'b1;
        data0_d  = shift_res;
      end else if (bus.resp0_ready) begin
        vld_d[0] = 1'b0;
      end
      if (grant1) begin
        vld_d[1] = 1'b1;
        data1_d  = shift_res;
      end else if (bus.resp1_ready) begin
        vld_d[1] = 1'b0;
      end
      if (grant0)      last_d = 1'b0;
      else if (grant1) last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 2'b00;
      data0_q <= '0;
      data1_q <= '0;
      last_q  <= 1'b1;
    end else begin
      vld_q   <= vld_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      last_q  <= last_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = vld_q[0];
  assign bus.resp1_valid = vld_q[1];
  assign bus.resp0_data  = data0_q;
  assign bus.resp1_data  = data1_q;

endmodule
